// File: rtl/picosoc_mem_arbiter.sv
// Two-master arbiter for the PicoSoC native memory bus (m0 = CPU, m1 = second requester).
// Optional hung-slave timeout is enabled by defining PICOSOC_ARB_TIMEOUT_EN.
module picosoc_mem_arbiter #(
  parameter bit          FIXED_PRIO     = 1'b0,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd1024,
  parameter logic [31:0] TIMEOUT_RDATA  = 32'hDEAD_BEEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_valid,
  output logic        m0_ready,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wstrb,
  output logic [31:0] m0_rdata,
  input  logic        m1_valid,
  output logic        m1_ready,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wstrb,
  output logic [31:0] m1_rdata,
  output logic        s_valid,
  input  logic        s_ready,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  output logic [3:0]  s_wstrb,
  input  logic [31:0] s_rdata,
  output logic [1:0]  grant,
  output logic        err_timeout,
  input  logic        err_clr
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GNT0 = 2'd1,
    ST_GNT1 = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        rr_last_q, rr_last_d;   // 1: m1 held the last grant
  logic        own_valid;
  logic        xfer_done;
  logic        tmo_hit;

  // Request of whichever master currently owns the bus.
  assign own_valid = ((state_q == ST_GNT0) & m0_valid) | ((state_q == ST_GNT1) & m1_valid);
  assign xfer_done = s_valid & s_ready;

`ifdef PICOSOC_ARB_TIMEOUT_EN
  logic [31:0] tmo_cnt_q, tmo_cnt_d;
  logic        err_timeout_q, err_timeout_d;

  assign tmo_hit     = own_valid & (tmo_cnt_q == (TIMEOUT_CYCLES - 32'd1));
  assign err_timeout = err_timeout_q;

  // Counter is zero in IDLE, so every grant starts counting from zero.
  always_comb begin
    tmo_cnt_d     = tmo_cnt_q;
    err_timeout_d = err_timeout_q;
    if (state_q == ST_IDLE) begin
      tmo_cnt_d = 32'd0;
    end else if (!s_ready) begin
      tmo_cnt_d = tmo_cnt_q + 32'd1;
    end
    if (tmo_hit) begin
      err_timeout_d = 1'b1;
    end else if (err_clr) begin
      err_timeout_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tmo_cnt_q     <= 32'd0;
      err_timeout_q <= 1'b0;
    end else begin
      tmo_cnt_q     <= tmo_cnt_d;
      err_timeout_q <= err_timeout_d;
    end
  end
`else
  logic [64:0] unused_c;

  assign unused_c    = {err_clr, TIMEOUT_CYCLES, TIMEOUT_RDATA};
  assign tmo_hit     = 1'b0;
  assign err_timeout = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      rr_last_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      rr_last_q <= rr_last_d;
    end
  end

  // Next-state: arbitrate in IDLE, release on completion, abandon or timeout.
  always_comb begin
    state_d   = state_q;
    rr_last_d = rr_last_q;
    case (state_q)
      ST_IDLE: begin
        if (m0_valid && (!m1_valid || FIXED_PRIO || rr_last_q)) begin
          state_d   = ST_GNT0;
          rr_last_d = 1'b0;
        end else if (m1_valid) begin
          state_d   = ST_GNT1;
          rr_last_d = 1'b1;
        end
      end
      ST_GNT0, ST_GNT1: begin
        if (!own_valid || xfer_done || tmo_hit) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs: bus mux follows the owner combinationally; the loser sees nothing.
  always_comb begin
    s_valid  = 1'b0;
    s_addr   = 32'd0;
    s_wdata  = 32'd0;
    s_wstrb  = 4'd0;
    m0_ready = 1'b0;
    m1_ready = 1'b0;
    m0_rdata = 32'd0;
    m1_rdata = 32'd0;
    grant    = 2'b00;
    case (state_q)
      ST_GNT0: begin
        grant    = 2'b01;
        s_valid  = m0_valid & ~tmo_hit;
        s_addr   = m0_addr;
        s_wdata  = m0_wdata;
        s_wstrb  = m0_wstrb;
        m0_ready = (m0_valid & ~tmo_hit & s_ready) | tmo_hit;
        m0_rdata = tmo_hit ? TIMEOUT_RDATA : s_rdata;
      end
      ST_GNT1: begin
        grant    = 2'b10;
        s_valid  = m1_valid & ~tmo_hit;
        s_addr   = m1_addr;
        s_wdata  = m1_wdata;
        s_wstrb  = m1_wstrb;
        m1_ready = (m1_valid & ~tmo_hit & s_ready) | tmo_hit;
        m1_rdata = tmo_hit ? TIMEOUT_RDATA : s_rdata;
      end
      default: ;
    endcase
  end

endmodule
